// File: rtl/iram_loader.sv
// Instruction-RAM loader: turns a framed UART byte stream into sequential 16-bit
// IRAM writes, holding the core during the load and pulsing its reset afterwards.
module iram_loader #(
    parameter int         WIDTH          = 16,
    parameter int         IRAM_ADDR_BITS = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [IRAM_ADDR_BITS-1:0] iram_wa,
    output logic                      iram_wen,
    output logic [WIDTH-1:0]          iram_din,
    output logic                      cpu_hold,
    output logic                      cpu_rst,
    output logic                      busy,
    output logic                      load_done,
    output logic                      load_err
);

    localparam int AW = IRAM_ADDR_BITS;
    localparam int LW = IRAM_ADDR_BITS + 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_HI, S_LO, S_CSUM} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [LW-1:0]     left_q, left_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        sum_q, sum_d;
    logic [AW-1:0]     wa_q, wa_d;
    logic [WIDTH-1:0]  din_q, din_d;
    logic              wen_q, wen_d;
    logic              hold_q, hold_d;
    logic              rst_q, rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [TW-1:0]     tmo_inc;
    logic              expire;
    logic [7:0]        sum_next;

    assign tmo_inc  = tmo_q + TW'(1);
    assign expire   = (state_q != S_IDLE) && !rx_valid && (tmo_inc == TW'(TIMEOUT_CYCLES - 1));
    assign sum_next = sum_q + rx_data;

    // NOTE: every flop updates with <= so all _q values read in this edge are pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            tmo_q   <= '0;
            left_q  <= '0;
            idx_q   <= '0;
            hi_q    <= '0;
            sum_q   <= '0;
            wa_q    <= '0;
            din_q   <= '0;
            wen_q   <= 1'b0;
            hold_q  <= 1'b0;
            rst_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            left_q  <= left_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            sum_q   <= sum_d;
            wa_q    <= wa_d;
            din_q   <= din_d;
            wen_q   <= wen_d;
            hold_q  <= hold_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // NOTE: each signal assigned below gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        if (expire) begin
            state_d = S_IDLE;
        end else if (rx_valid) begin
            unique case (state_q)
                S_IDLE:  if (rx_data == SYNC_BYTE) state_d = S_COUNT;
                S_COUNT: state_d = S_HI;
                S_HI:    state_d = S_LO;
                S_LO:    state_d = (left_q == LW'(1)) ? S_CSUM : S_HI;
                S_CSUM:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_comb begin
        tmo_d  = (state_q == S_IDLE || rx_valid || expire) ? '0 : tmo_inc;
        left_d = left_q;
        idx_d  = idx_q;
        hi_d   = hi_q;
        sum_d  = sum_q;
        wa_d   = wa_q;
        din_d  = din_q;
        wen_d  = 1'b0;
        hold_d = hold_q;
        rst_d  = 1'b0;
        done_d = 1'b0;
        err_d  = expire;
        if (rx_valid) begin
            unique case (state_q)
                S_IDLE: if (rx_data == SYNC_BYTE) hold_d = 1'b1;
                S_COUNT: begin
                    // A count of zero means the full RAM depth.
                    left_d = (rx_data == 8'h00) ? (LW'(1) << AW) : LW'(rx_data);
                    idx_d  = '0;
                    sum_d  = rx_data;
                end
                S_HI: begin
                    hi_d  = rx_data;
                    sum_d = sum_next;
                end
                S_LO: begin
                    sum_d  = sum_next;
                    wen_d  = 1'b1;
                    wa_d   = idx_q;
                    din_d  = WIDTH'({hi_q, rx_data});
                    idx_d  = idx_q + AW'(1);
                    left_d = left_q - LW'(1);
                end
                S_CSUM: begin
                    sum_d = sum_next;
                    if (sum_next == 8'h00) begin
                        done_d = 1'b1;
                        rst_d  = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign iram_wa   = wa_q;
    assign iram_wen  = wen_q;
    assign iram_din  = din_q;
    assign cpu_hold  = hold_q;
    assign cpu_rst   = rst_q;
    assign busy      = busy_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader: frames with hand-computed checksums, write
// timing, error/timeout handling and mid-frame reset.
module tb_iram_loader;

    localparam int AW = 8;
    localparam int TMO = 50;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [AW-1:0] iram_wa;
    logic          iram_wen;
    logic [15:0]   iram_din;
    logic          cpu_hold, cpu_rst, busy, load_done, load_err;

    iram_loader #(
        .WIDTH(16), .IRAM_ADDR_BITS(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .iram_wa(iram_wa), .iram_wen(iram_wen), .iram_din(iram_din),
        .cpu_hold(cpu_hold), .cpu_rst(cpu_rst), .busy(busy),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write log and pulse counters, sampled mid-cycle
    logic [AW-1:0] log_wa[$];
    logic [15:0]   log_din[$];
    int done_cnt = 0, err_cnt = 0, rst_cnt = 0;

    always @(negedge clk) begin
        if (iram_wen) begin
            log_wa.push_back(iram_wa);
            log_din.push_back(iram_din);
        end
        if (load_done) done_cnt++;
        if (load_err)  err_cnt++;
        if (cpu_rst)   rst_cnt++;
    end

    // Per-byte snapshot one clock after each byte is strobed; first byte ends up in the MSB
    logic [7:0] frame[$];
    logic [15:0] wen_bits, hold_bits, done_bits, err_bits, rst_bits, busy_bits;

    task automatic record();
        wen_bits  = {wen_bits[14:0],  iram_wen};
        hold_bits = {hold_bits[14:0], cpu_hold};
        done_bits = {done_bits[14:0], load_done};
        err_bits  = {err_bits[14:0],  load_err};
        rst_bits  = {rst_bits[14:0],  cpu_rst};
        busy_bits = {busy_bits[14:0], busy};
    endtask

    task automatic send_frame();
        wen_bits = '0; hold_bits = '0; done_bits = '0;
        err_bits = '0; rst_bits = '0; busy_bits = '0;
        foreach (frame[i]) begin
            @(negedge clk);
            if (i > 0) record();
            rx_valid = 1'b1;
            rx_data  = frame[i];
        end
        @(negedge clk);
        record();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int base_wr, base_done, base_err, base_rst, edges, bad;

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(3);
        check("reset_outputs", {iram_wa, iram_din, iram_wen, cpu_hold, cpu_rst, busy, load_done, load_err}, 32'h0);
        reset = 1'b0;
        idle(2);

        // Good two-word frame: 02+12+34+AB+CD = 0xC0, checksum 0x40
        base_wr = log_wa.size(); base_done = done_cnt; base_rst = rst_cnt;
        frame = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_frame();
        idle(3);
        check("good_wen_timing", 32'(wen_bits[6:0]), 32'h0A);
        check("good_hold_trace", 32'(hold_bits[6:0]), 32'h7E);
        check("good_busy_trace", 32'(busy_bits[6:0]), 32'h7E);
        check("good_done_trace", 32'(done_bits[6:0]), 32'h01);
        check("good_rst_trace",  32'(rst_bits[6:0]), 32'h01);
        check("good_n_writes", 32'(log_wa.size() - base_wr), 32'd2);
        check("good_w0_addr", 32'(log_wa[base_wr]), 32'h00);
        check("good_w0_data", 32'(log_din[base_wr]), 32'h1234);
        check("good_w1_addr", 32'(log_wa[base_wr+1]), 32'h01);
        check("good_w1_data", 32'(log_din[base_wr+1]), 32'hABCD);
        check("good_done_once", 32'(done_cnt - base_done), 32'd1);
        check("good_rst_once", 32'(rst_cnt - base_rst), 32'd1);
        check("good_wa_held", 32'(iram_wa), 32'h01);
        check("good_din_held", 32'(iram_din), 32'hABCD);

        // Same frame with checksum 0x41: writes happen, load fails, core stays held
        base_wr = log_wa.size(); base_done = done_cnt; base_err = err_cnt; base_rst = rst_cnt;
        frame = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        send_frame();
        idle(3);
        check("bad_n_writes", 32'(log_wa.size() - base_wr), 32'd2);
        check("bad_err_trace", 32'(err_bits[6:0]), 32'h01);
        check("bad_hold_trace", 32'(hold_bits[6:0]), 32'h7F);
        check("bad_err_once", 32'(err_cnt - base_err), 32'd1);
        check("bad_no_done", 32'(done_cnt - base_done), 32'd0);
        check("bad_no_rst", 32'(rst_cnt - base_rst), 32'd0);
        check("bad_hold_kept", 32'(cpu_hold), 32'd1);
        frame = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_frame();
        idle(3);
        check("recover_hold_clear", 32'(cpu_hold), 32'd0);
        check("recover_done", 32'(done_cnt - base_done), 32'd1);

        // Non-sync bytes while idle are ignored
        base_wr = log_wa.size();
        frame = '{8'h00, 8'hFF, 8'h12};
        send_frame();
        idle(2);
        check("idle_busy_trace", 32'(busy_bits[2:0]), 32'h0);
        check("idle_hold_trace", 32'(hold_bits[2:0]), 32'h0);
        check("idle_no_writes", 32'(log_wa.size() - base_wr), 32'd0);
        // Embedded A5 data byte: 01+A5+A5 = 0x14B -> checksum 0xB5
        base_done = done_cnt;
        frame = '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hB5};
        send_frame();
        idle(3);
        check("after_idle_writes", 32'(log_wa.size() - base_wr), 32'd1);
        check("after_idle_data", 32'(log_din[base_wr]), 32'hA5A5);
        check("after_idle_addr", 32'(log_wa[base_wr]), 32'h00);
        check("after_idle_done", 32'(done_cnt - base_done), 32'd1);

        // Timeout: A5 01 12 then silence; error registered on the 49th edge after byte 12
        base_wr = log_wa.size(); base_err = err_cnt;
        frame = '{8'hA5, 8'h01, 8'h12};
        send_frame();
        check("tmo_busy_trace", 32'(busy_bits[2:0]), 32'h7);
        edges = 0;
        while (!load_err && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        check("tmo_edge", 32'(edges), 32'd49);
        check("tmo_idle", 32'(busy), 32'd0);
        check("tmo_hold", 32'(cpu_hold), 32'd1);
        idle(1);
        check("tmo_err_pulse", 32'(load_err), 32'd0);
        check("tmo_err_once", 32'(err_cnt - base_err), 32'd1);
        check("tmo_no_write", 32'(log_wa.size() - base_wr), 32'd0);

        // Full-depth frame: N=0, word k = {k, ~k}; all words sum to 0 so checksum is 0
        base_wr = log_wa.size(); base_done = done_cnt;
        frame = '{8'hA5, 8'h00};
        for (int k = 0; k < 256; k++) begin
            frame.push_back(8'(k));
            frame.push_back(~8'(k));
        end
        frame.push_back(8'h00);
        send_frame();
        idle(3);
        check("full_n_writes", 32'(log_wa.size() - base_wr), 32'd256);
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (log_wa[base_wr+k] !== 8'(k) || log_din[base_wr+k] !== {8'(k), ~8'(k)}) bad++;
        end
        check("full_contents", 32'(bad), 32'd0);
        check("full_last_addr", 32'(log_wa[base_wr+255]), 32'hFF);
        check("full_last_data", 32'(log_din[base_wr+255]), 32'hFF00);
        check("full_done", 32'(done_cnt - base_done), 32'd1);
        check("full_hold", 32'(cpu_hold), 32'd0);

        // Reset between the HI and LO bytes of word 1
        base_wr = log_wa.size();
        frame = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB};
        send_frame();
        reset = 1'b1;
        #1;
        check("midrst_outputs", {iram_wa, iram_din, iram_wen, cpu_hold, cpu_rst, busy, load_done, load_err}, 32'h0);
        idle(3);
        reset = 1'b0;
        idle(2);
        check("midrst_one_write", 32'(log_wa.size() - base_wr), 32'd1);
        check("midrst_w0_addr", 32'(log_wa[base_wr]), 32'h00);
        // Fresh frame: 01+55+66 = 0xBC -> checksum 0x44
        base_wr = log_wa.size(); base_done = done_cnt;
        frame = '{8'hA5, 8'h01, 8'h55, 8'h66, 8'h44};
        send_frame();
        idle(3);
        check("fresh_n_writes", 32'(log_wa.size() - base_wr), 32'd1);
        check("fresh_addr", 32'(log_wa[base_wr]), 32'h00);
        check("fresh_data", 32'(log_din[base_wr]), 32'h5566);
        check("fresh_done", 32'(done_cnt - base_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
